// File: rtl/sram_axi_bridge_pkg.sv
// Shared types and constants for the SRAM-style to AXI3 bridge.
package sram_axi_bridge_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_REQ,
    S_WR_RESP,
    S_DONE
  } state_t;

  localparam logic [3:0] INST_ID_DEF = 4'd0;
  localparam logic [3:0] DATA_ID_DEF = 4'd1;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Requester size to AXI AxSIZE; the reserved code 3 is treated as a word.
  function automatic logic [2:0] axi_size(input logic [1:0] sz);
    return (sz == 2'd3) ? 3'd2 : {1'b0, sz};
  endfunction

endpackage

// File: rtl/sram_axi_bridge_strb_gen.sv
// Byte-lane write strobe from transfer size and low address bits.
module sram_axi_bridge_strb_gen
  import sram_axi_bridge_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] wstrb
);

  always_comb begin
    wstrb = 4'b1111;
    case (size)
      SZ_BYTE: wstrb = 4'b0001 << addr_lo;
      SZ_HALF: wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: wstrb = 4'b1111;
    endcase
  end

endmodule

// File: rtl/sram_axi_bridge.sv
// Instruction/data request-ack ports to a single-beat, one-outstanding AXI3 master.
module sram_axi_bridge
  import sram_axi_bridge_pkg::*;
#(
  parameter logic [3:0] INST_ID = INST_ID_DEF,
  parameter logic [3:0] DATA_ID = DATA_ID_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  state_t      state_q, state_d;
  logic        owner_q;  // 1 = data port owns the transaction
  logic        wr_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, rbuf_q;
  logic        aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic        idle, accept;

  assign idle         = (state_q == S_IDLE);
  assign data_addr_ok = idle & data_req;
  assign inst_addr_ok = idle & inst_req & ~data_req;
  assign accept       = data_addr_ok | inst_addr_ok;

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      S_IDLE:    if (accept) state_d = (data_req && data_wr) ? S_WR_REQ : S_RD_ADDR;
      S_RD_ADDR: if (arready) state_d = S_RD_DATA;
      S_RD_DATA: if (rvalid) state_d = S_DONE;
      S_WR_REQ: begin
        aw_done_d = aw_done_q | (awvalid & awready);
        w_done_d  = w_done_q  | (wvalid & wready);
        if (aw_done_d && w_done_d) begin
          state_d   = S_WR_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      S_WR_RESP: if (bvalid) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      wr_q      <= 1'b0;
      size_q    <= 2'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      rbuf_q    <= 32'd0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      if (accept) begin
        owner_q <= data_req;
        wr_q    <= data_req & data_wr;
        size_q  <= data_req ? data_size  : inst_size;
        addr_q  <= data_req ? data_addr  : inst_addr;
        wdata_q <= data_req ? data_wdata : 32'd0;
      end
      if (state_q == S_RD_DATA && rvalid) rbuf_q <= rdata;
    end
  end

  // AXI fields come straight from the latched request, so they stay stable while valid waits.
  assign arid    = owner_q ? DATA_ID : INST_ID;
  assign araddr  = addr_q;
  assign arsize  = axi_size(size_q);
  assign arvalid = (state_q == S_RD_ADDR);
  assign rready  = (state_q == S_RD_DATA);

  assign awid    = DATA_ID;
  assign awaddr  = addr_q;
  assign awsize  = axi_size(size_q);
  assign awvalid = (state_q == S_WR_REQ) & ~aw_done_q;
  assign wdata   = wdata_q;
  assign wvalid  = (state_q == S_WR_REQ) & ~w_done_q;
  assign wlast   = wvalid;
  assign bready  = (state_q == S_WR_RESP);

  sram_axi_bridge_strb_gen u_strb (
    .size    (size_q),
    .addr_lo (addr_q[1:0]),
    .wstrb   (wstrb)
  );

  assign inst_data_ok = (state_q == S_DONE) & ~owner_q;
  assign data_data_ok = (state_q == S_DONE) & owner_q;
  assign inst_rdata   = rbuf_q;
  assign data_rdata   = rbuf_q;

  // Responses are single-beat and errors are not reported upstream.
  logic unused_ok;
  assign unused_ok = ^{rresp, rlast, bresp, wr_q};

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: reads, arbitration, strobes, AW/W skew, backpressure, reset.
module tb_sram_axi_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic [3:0]  arid, awid, wstrb;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [2:0]  arsize, awsize;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sram_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Skewed write: awready rises after awd cycles, wready after wd cycles.
  task automatic skew_write(input int awd, input int wd);
    int mx;
    mx = (awd > wd) ? awd : wd;
    tick;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2;
    data_addr = 32'h8000_0040; data_wdata = 32'h0F0F_0F0F;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
    #1 chk("skew_accept", data_addr_ok, 1);
    tick;
    data_req = 1'b0;
    for (int k = 0; k <= mx; k++) begin
      awready = (k >= awd);
      wready  = (k >= wd);
      #1;
      chk("skew_awvalid", awvalid, (k <= awd));
      chk("skew_wvalid", wvalid, (k <= wd));
      chk("skew_awaddr", awaddr, 32'h8000_0040);
      chk("skew_bready_early", bready, 0);
      tick;
    end
    awready = 1'b1; wready = 1'b1;
    #1 chk("skew_bready", bready, 1);
    tick;
    #1 chk("skew_data_ok", data_data_ok, 1);
    tick;
  endtask

  typedef struct {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  strb;
    logic [2:0]  axsz;
  } wr_vec_t;

  wr_vec_t wv[5];

  initial begin
    wv[0] = '{2'd0, 32'h8000_0003, 32'hAB00_0000, 4'b1000, 3'd0};
    wv[1] = '{2'd1, 32'h8000_0002, 32'hBEEF_0000, 4'b1100, 3'd1};
    wv[2] = '{2'd2, 32'h8000_0010, 32'h1234_5678, 4'b1111, 3'd2};
    wv[3] = '{2'd0, 32'h8000_0021, 32'h0000_5500, 4'b0010, 3'd0};
    wv[4] = '{2'd3, 32'h8000_0030, 32'hDEAD_BEEF, 4'b1111, 3'd2};

    resetn = 1'b0;
    inst_req = 0; inst_size = 0; inst_addr = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
    arready = 1; rdata = 0; rresp = 0; rlast = 1; rvalid = 1;
    awready = 1; wready = 1; bresp = 0; bvalid = 1;
    #1;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_bready", bready, 0);
    chk("rst_data_ok", {inst_data_ok, data_data_ok}, 0);
    chk("rst_rdata", inst_rdata, 0);
    chk("rst_araddr", araddr, 0);
    tick; tick;
    resetn = 1'b1;

    // Instruction read with all readies high.
    tick;
    inst_req = 1; inst_addr = 32'hBFC0_0000; inst_size = 2; rdata = 32'h3C1D_0001;
    #1 chk("i_addr_ok", inst_addr_ok, 1);
    tick;
    inst_req = 0;
    #1;
    chk("i_arvalid", arvalid, 1);
    chk("i_arid", arid, 0);
    chk("i_arsize", arsize, 2);
    chk("i_araddr", araddr, 32'hBFC0_0000);
    chk("i_data_ok_t1", inst_data_ok, 0);
    tick;
    #1 chk("i_rready", rready, 1);
    tick;
    #1;
    chk("i_data_ok", inst_data_ok, 1);
    chk("i_rdata", inst_rdata, 32'h3C1D_0001);
    chk("i_no_d_ok", data_data_ok, 0);
    tick;
    #1 chk("i_data_ok_pulse", inst_data_ok, 0);

    // Arbitration: data wins, inst waits.
    tick;
    inst_req = 1; inst_addr = 32'hBFC0_0004; inst_size = 2;
    data_req = 1; data_wr = 0; data_addr = 32'h8000_1000; data_size = 2;
    rdata = 32'h1111_2222;
    #1;
    chk("arb_d_ok", data_addr_ok, 1);
    chk("arb_i_ok", inst_addr_ok, 0);
    tick;
    data_req = 0;
    #1;
    chk("arb_arid", arid, 1);
    chk("arb_araddr", araddr, 32'h8000_1000);
    chk("arb_i_busy", inst_addr_ok, 0);
    tick;
    tick;
    rdata = 32'hAAAA_5555;
    #1;
    chk("arb_d_data_ok", data_data_ok, 1);
    chk("arb_d_rdata", data_rdata, 32'h1111_2222);
    chk("arb_i_data_ok", inst_data_ok, 0);
    tick;
    #1 chk("arb_i_accept", inst_addr_ok, 1);
    tick;
    inst_req = 0;
    #1;
    chk("arb_i_arid", arid, 0);
    chk("arb_i_araddr", araddr, 32'hBFC0_0004);
    tick; tick;
    #1;
    chk("arb_i_done", inst_data_ok, 1);
    chk("arb_i_rdata", inst_rdata, 32'hAAAA_5555);
    tick;

    // Sized writes, readies high.
    foreach (wv[i]) begin
      tick;
      data_req = 1; data_wr = 1; data_size = wv[i].size;
      data_addr = wv[i].addr; data_wdata = wv[i].wd;
      #1 chk("w_addr_ok", data_addr_ok, 1);
      tick;
      data_req = 0;
      #1;
      chk("w_awvalid", awvalid, 1);
      chk("w_wvalid", wvalid, 1);
      chk("w_wlast", wlast, 1);
      chk("w_wstrb", wstrb, wv[i].strb);
      chk("w_wdata", wdata, wv[i].wd);
      chk("w_awaddr", awaddr, wv[i].addr);
      chk("w_awsize", awsize, wv[i].axsz);
      chk("w_awid", awid, 1);
      tick;
      #1 chk("w_bready", bready, 1);
      tick;
      #1 chk("w_data_ok", data_data_ok, 1);
      tick;
      #1 chk("w_data_ok_pulse", data_data_ok, 0);
    end

    skew_write(3, 0);
    skew_write(0, 3);
    skew_write(2, 2);

    // Read backpressure with an error response.
    tick;
    data_req = 1; data_wr = 0; data_addr = 32'h8000_2000; data_size = 1;
    arready = 0; rvalid = 0; rresp = 2'b10; rdata = 32'hCAFE_F00D;
    #1 chk("bp_accept", data_addr_ok, 1);
    tick;
    data_req = 0;
    for (int k = 0; k <= 5; k++) begin
      arready = (k == 5);
      #1;
      chk("bp_arvalid", arvalid, 1);
      chk("bp_araddr", araddr, 32'h8000_2000);
      chk("bp_arsize", arsize, 1);
      tick;
    end
    for (int k = 0; k <= 4; k++) begin
      rvalid = (k == 4);
      #1;
      chk("bp_rready", rready, 1);
      chk("bp_no_ok", data_data_ok, 0);
      tick;
    end
    #1;
    chk("bp_data_ok", data_data_ok, 1);
    chk("bp_rdata", data_rdata, 32'hCAFE_F00D);
    tick;
    #1 chk("bp_data_ok_pulse", data_data_ok, 0);
    arready = 1; rvalid = 1; rresp = 0;

    // Reset while waiting for B.
    tick;
    data_req = 1; data_wr = 1; data_size = 2; data_addr = 32'h8000_3000;
    data_wdata = 32'h7777_7777; bvalid = 0;
    tick;
    data_req = 0;
    tick;
    #1 chk("rstm_bready_before", bready, 1);
    resetn = 0;
    #1;
    chk("rstm_arvalid", arvalid, 0);
    chk("rstm_awvalid", awvalid, 0);
    chk("rstm_wvalid", wvalid, 0);
    chk("rstm_bready", bready, 0);
    chk("rstm_data_ok", {inst_data_ok, data_data_ok}, 0);
    tick;
    resetn = 1; bvalid = 1;
    #1 chk("rstm_no_ok_after", data_data_ok, 0);
    tick;
    inst_req = 1; inst_addr = 32'hBFC0_0100; inst_size = 2; rdata = 32'h5A5A_0F0F;
    #1 chk("rstm_accept", inst_addr_ok, 1);
    tick;
    inst_req = 0;
    #1 chk("rstm_arvalid_new", arvalid, 1);
    tick; tick;
    #1;
    chk("rstm_i_data_ok", inst_data_ok, 1);
    chk("rstm_i_rdata", inst_rdata, 32'h5A5A_0F0F);
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
